// File: rtl/pact_vector_int_mac.sv
// pact_vector_int_mac: multi-lane pipelined integer multiply / multiply-accumulate
// with round-half-up requantisation, per-lane saturation and output backpressure.
// Stage 0 holds the operands, the product is formed from stage 0 and carried down
// the remaining stages, and the final stage accumulates, requantises and emits.
module pact_vector_int_mac #(
  parameter int NUM_LANES = 4,
  parameter int BW_INPUT  = 8,
  parameter int BW_OUTPUT = 16,
  parameter int BW_GUARD  = 8,
  parameter int BW_SHIFT  = 5,
  parameter int LATENCY   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES*BW_INPUT-1:0]  in_left,
  input  logic [NUM_LANES*BW_INPUT-1:0]  in_right,
  input  logic                           in_signed,
  input  logic                           in_acc,
  input  logic                           in_last,
  input  logic [BW_SHIFT-1:0]            in_shift,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*BW_OUTPUT-1:0] out_result,
  output logic [NUM_LANES-1:0]           out_saturated
);

  localparam int BW_ACC  = 2*BW_INPUT + BW_GUARD;
  localparam int BW_PROD = 2*BW_INPUT + 2;
  // Wide enough that the rounding constant for the largest shift never overflows.
  localparam int BW_WIDE = BW_ACC + (1 << BW_SHIFT) + 1;
  localparam int FIN     = LATENCY - 2;

  localparam logic signed [BW_WIDE-1:0] S_MAX = {{(BW_WIDE-BW_OUTPUT+1){1'b0}}, {(BW_OUTPUT-1){1'b1}}};
  localparam logic signed [BW_WIDE-1:0] S_MIN = {{(BW_WIDE-BW_OUTPUT+1){1'b1}}, {(BW_OUTPUT-1){1'b0}}};
  localparam logic signed [BW_WIDE-1:0] U_MAX = {{(BW_WIDE-BW_OUTPUT){1'b0}}, {BW_OUTPUT{1'b1}}};

  logic adv;
  logic emit;

  logic [LATENCY-2:0]               s_valid;
  logic [LATENCY-2:0]               s_signed;
  logic [LATENCY-2:0]               s_acc;
  logic [LATENCY-2:0]               s_last;
  logic [LATENCY-2:0][BW_SHIFT-1:0] s_shift;
  logic [NUM_LANES*BW_INPUT-1:0]    s0_left;
  logic [NUM_LANES*BW_INPUT-1:0]    s0_right;

  logic [NUM_LANES-1:0][BW_ACC-1:0] prod0;
  logic [NUM_LANES-1:0][BW_ACC-1:0] fin_prod;
  logic [NUM_LANES-1:0][BW_ACC-1:0] acc;
  logic [NUM_LANES-1:0][BW_ACC-1:0] acc_sum;
  logic [NUM_LANES*BW_OUTPUT-1:0]   res_next;
  logic [NUM_LANES-1:0]             sat_next;

  // The whole pipeline moves only when enabled and the output slot is free or being drained.
  assign adv      = enable & ~(out_valid & ~out_ready);
  assign in_ready = adv;
  assign emit     = s_valid[FIN] & (~s_acc[FIN] | s_last[FIN]);

  // Operand capture and control fields travelling alongside each beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= '0;
    end else if (adv) begin
      s_valid[0]  <= in_valid;
      s_signed[0] <= in_signed;
      s_acc[0]    <= in_acc;
      s_last[0]   <= in_last;
      s_shift[0]  <= in_shift;
      s0_left     <= in_left;
      s0_right    <= in_right;
      for (int k = 1; k <= FIN; k++) begin
        s_valid[k]  <= s_valid[k-1];
        s_signed[k] <= s_signed[k-1];
        s_acc[k]    <= s_acc[k-1];
        s_last[k]   <= s_last[k-1];
        s_shift[k]  <= s_shift[k-1];
      end
    end
  end

  // Full-width per-lane product, sign- or zero-extended to the accumulator width.
  always_comb begin : mult_lanes
    logic signed [BW_INPUT:0] a_ext;
    logic signed [BW_INPUT:0] b_ext;
    logic signed [BW_PROD-1:0] prod_w;
    prod0 = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      a_ext = s_signed[0] ? {s0_left[i*BW_INPUT+BW_INPUT-1],  s0_left[i*BW_INPUT +: BW_INPUT]}
                          : {1'b0, s0_left[i*BW_INPUT +: BW_INPUT]};
      b_ext = s_signed[0] ? {s0_right[i*BW_INPUT+BW_INPUT-1], s0_right[i*BW_INPUT +: BW_INPUT]}
                          : {1'b0, s0_right[i*BW_INPUT +: BW_INPUT]};
      prod_w   = a_ext * b_ext;
      prod0[i] = {{(BW_ACC-BW_PROD){prod_w[BW_PROD-1]}}, prod_w};
    end
  end

  generate
    if (LATENCY == 2) begin : g_short
      assign fin_prod = prod0;
    end else begin : g_deep
      logic [NUM_LANES-1:0][BW_ACC-1:0] p_prod [LATENCY-2];
      // Carry the product down to the final stage.
      always_ff @(posedge clk) begin
        if (adv) begin
          p_prod[0] <= prod0;
          for (int k = 1; k < LATENCY-2; k++) begin
            p_prod[k] <= p_prod[k-1];
          end
        end
      end
      assign fin_prod = p_prod[LATENCY-3];
    end
  endgenerate

  // Final-stage value selection, round-half-up shift and saturation for each lane.
  always_comb begin : requant
    logic [BW_ACC-1:0]         value;
    logic signed [BW_WIDE-1:0] v_ext;
    logic signed [BW_WIDE-1:0] rnd;
    logic signed [BW_WIDE-1:0] r;
    acc_sum  = '0;
    res_next = '0;
    sat_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      acc_sum[i] = acc[i] + fin_prod[i];
      value = s_acc[FIN] ? acc_sum[i] : fin_prod[i];
      v_ext = s_signed[FIN] ? {{(BW_WIDE-BW_ACC){value[BW_ACC-1]}}, value}
                            : {{(BW_WIDE-BW_ACC){1'b0}}, value};
      rnd   = (s_shift[FIN] != '0) ? (BW_WIDE'(1) << (s_shift[FIN] - 1'b1)) : '0;
      r     = (v_ext + rnd) >>> s_shift[FIN];
      res_next[i*BW_OUTPUT +: BW_OUTPUT] = r[BW_OUTPUT-1:0];
      if (s_signed[FIN]) begin
        if (r > S_MAX) begin
          res_next[i*BW_OUTPUT +: BW_OUTPUT] = S_MAX[BW_OUTPUT-1:0];
          sat_next[i] = 1'b1;
        end else if (r < S_MIN) begin
          res_next[i*BW_OUTPUT +: BW_OUTPUT] = S_MIN[BW_OUTPUT-1:0];
          sat_next[i] = 1'b1;
        end
      end else if (r > U_MAX) begin
        res_next[i*BW_OUTPUT +: BW_OUTPUT] = U_MAX[BW_OUTPUT-1:0];
        sat_next[i] = 1'b1;
      end
    end
  end

  // Per-lane accumulators: add on open beats, clear when the closing beat emits.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (adv && s_valid[FIN] && s_acc[FIN]) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        acc[i] <= s_last[FIN] ? '0 : acc_sum[i];
      end
    end
  end

  // Output register; holds its contents whenever the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_saturated <= '0;
    end else if (adv) begin
      out_valid <= emit;
      if (emit) begin
        out_result    <= res_next;
        out_saturated <= sat_next;
      end
    end
  end

endmodule

// File: doc/pact_vector_int_mac.md
Name: pact_vector_int_mac

Overview:
- Multi-lane pipelined integer multiply / multiply-accumulate unit for tensor scalar datapaths.
- Generalises the single-scalar int multiplier in three ways: NUM_LANES parallel lanes, optional per-lane accumulation across beats, and round-shift-saturate requantisation.
- Adds full valid/ready backpressure on the output, which the single-scalar multiplier does not have.
- Sits between tensor operand fetch and the result writeback buffer.

Parameters:
- NUM_LANES, 4, number of independent lanes.
- BW_INPUT, 8, operand width per lane.
- BW_OUTPUT, 16, result width per lane; must be ≤ 2*BW_INPUT+BW_GUARD.
- BW_GUARD, 8, accumulator guard bits; accumulator width BW_ACC = 2*BW_INPUT+BW_GUARD.
- BW_SHIFT, 5, width of the requantisation shift amount.
- LATENCY, 3, pipeline depth in cycles; must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  global enable; 0 freezes all state.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- in_left  in  NUM_LANES*BW_INPUT  left operands; lane i at [i*BW_INPUT +: BW_INPUT].
- in_right  in  NUM_LANES*BW_INPUT  right operands, same packing.
- in_signed  in  1  1 = two's-complement operands and result; 0 = unsigned.
- in_acc  in  1  1 = accumulate this beat.
- in_last  in  1  with in_acc=1, closes the accumulation and emits the result.
- in_shift  in  BW_SHIFT  right-shift amount applied at emission.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&out_ready.
- out_result  out  NUM_LANES*BW_OUTPUT  per-lane results.
- out_saturated  out  NUM_LANES  per-lane saturation flag.

Behaviour:
- Reset, in the cycle rst=1 is sampled:
  - all stage valids = 0; out_valid = 0.
  - out_result = 0; out_saturated = 0.
  - every accumulator = 0.
  - rst has priority over enable.
- Advance: adv = enable & ~(out_valid & ~out_ready). in_ready = adv.
  - The whole pipeline shifts only when adv=1.
  - When adv=0, every stage register, accumulator and output register holds.
- Control fields in_signed, in_acc, in_last and in_shift are registered with each beat and travel alongside it.
- Product:
  - Full 2*BW_INPUT product, sign- or zero-extended to BW_ACC per the beat's in_signed.
  - Computed in stages 1..LATENCY-1.
- Final stage, on adv with a valid beat:
  - in_acc=0: value = product; the accumulator is not touched; a result is emitted.
  - in_acc=1, in_last=0: acc += product; nothing is emitted.
  - in_acc=1, in_last=1: value = acc + product; acc cleared to 0; a result is emitted.
  - Accumulator addition wraps at BW_ACC bits; software sizes the number of beats so this cannot occur.
- Requantise each emitted value using the closing beat's in_signed and in_shift:
  - r = (value + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic if signed, logical if unsigned; round half up.
  - Saturate r to the signed range [-2^(BW_OUTPUT-1), 2^(BW_OUTPUT-1)-1] or the unsigned range [0, 2^BW_OUTPUT-1].
  - out_saturated[i] = 1 iff lane i was clipped.
- Emission:
  - out_valid is asserted LATENCY cycles after acceptance when there is no stall.
  - out_result holds stable while out_valid & ~out_ready.
  - Beats leave in acceptance order; none are dropped or duplicated.
- Beats that do not emit still cost a pipeline slot; they produce no out_valid.
- Simultaneous output handshake and new acceptance in the same cycle is allowed; full throughput is 1 beat/cycle.
- Reset mid-accumulation discards the partial sum. The next beats start from acc=0.
- enable=0 with in_valid=1: in_ready=0 and no state change.

Test Plan:
- Signed multiply, no stall:
  - Stimulus: lane0 -3 (0xFD) × 7, shift 0, in_acc=0.
  - Response: out_valid exactly 3 cycles later; lane0 = 0xFFEB (-21); saturated = 0.
- Unsigned vs signed:
  - Unsigned 255×255, shift 0 → 0xFE01.
  - Signed 127×127 → 0x3F01.
- Saturation:
  - Unsigned: two acc beats of 255×255, last on the 2nd → 0xFFFF, saturated = 1.
  - Signed: two beats of -128×-128 → 0x7FFF, saturated = 1.
  - Signed: 127×-128 ×3 beats (-48768) → 0x8000, saturated = 1.
- Rounding:
  - 5×3, shift 2 → 4.
  - -5×3, shift 2 → -4 (0xFFFC).
  - 6×1, shift 2 → 2.
- Backpressure:
  - Stimulus: six back-to-back non-acc beats with values 1..6 (×1), out_ready=0 for 5 cycles after the first out_valid.
  - Response: in_ready drops, out_result holds 1, then 1..6 delivered in order with no loss.
- Reset mid-accumulation:
  - Stimulus: acc beats 10×10, 10×10, then rst pulse, then acc+last beat 1×1.
  - Response: result 1; out_valid and out_result are 0 during reset.
